pll_cfg_seq: RTL
================

Name: pll_cfg_seq

Overview:
Hardware sequencer for the pixel-clock PLL. Today software bit-bangs the PLL's serial config pins, nreset and bypass through the control register. This block replaces that with a single "load config" command. It resets and bypasses the PLL, shifts a config word out on sclk/sdi and captures the sdo readback. It then releases the PLL, waits for a qualified lock with a timeout, and finally releases the pixel-domain reset request. It sits in the clk domain between the control-register decode and the clocks block.

Parameters:
- CFG_BITS, 26: length of the PLL serial config word, shifted MSB first.
- SCLK_DIV, 4: clk cycles per sclk half-period; must be ≥1.
- RESET_HOLD, 16: clk cycles that pll_nreset is held low before shifting starts.
- LOCK_QUAL, 8: consecutive synchronised-lock cycles required to declare lock.
- LOCK_TIMEOUT, 65535: clk cycles allowed in WAIT_LOCK before flagging an error.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- cfg_data, in, CFG_BITS: config word; sampled on the accepted cfg_start.
- cfg_start, in, 1: single-cycle command pulse.
- cfg_busy, out, 1: high from the cycle after an accepted start until RUN or ERROR is reached.
- cfg_done, out, 1: sticky; set on entry to RUN, cleared by the next accepted start.
- cfg_error, out, 1: sticky; set on lock timeout, cleared by the next accepted start.
- lock_lost, out, 1: sticky; set on loss of lock while in RUN, cleared by the next accepted start.
- readback, out, CFG_BITS: sdo bits captured during the shift.
- pll_nreset, out, 1: PLL reset, active-low.
- pll_bypass, out, 1: PLL bypass.
- pll_sclk, out, 1: serial config clock.
- pll_sdi, out, 1: serial config data to the PLL.
- pll_sdo, in, 1: serial readback from the PLL.
- pll_locked, in, 1: asynchronous lock indication.
- pclk_reset_req, out, 1: pixel reset request; the consumer synchronises it into the pclk domain.

Behaviour:
- Reset values (every output, registered): pll_nreset=0, pll_bypass=1, pll_sclk=0, pll_sdi=0, pclk_reset_req=1, cfg_busy=0, cfg_done=0, cfg_error=0, lock_lost=0, readback=0. State is IDLE.
- Reset asserted mid-operation aborts immediately to these values. It does not wait for the sclk phase to complete.
- pll_locked passes through a 2-flop synchroniser; only the synchronised copy is used.
- cfg_start is accepted in IDLE, RUN and ERROR. It is ignored while cfg_busy=1.
- Accepting a start: latch cfg_data into the shift register, clear cfg_done, cfg_error and lock_lost, and go to ASSERT_RST.
- ASSERT_RST:
  - Outputs: pll_nreset=0, pll_bypass=1, pclk_reset_req=1, pll_sclk=0.
  - Stay exactly RESET_HOLD cycles, then go to SHIFT.
- SHIFT, per bit:
  - Phase low: SCLK_DIV cycles with sclk=0 and sdi = current MSB.
  - Phase high: SCLK_DIV cycles with sclk=1.
  - On the cycle sclk rises, sample pll_sdo into readback LSB (readback shifts left).
  - After the high phase, shift out the MSB.
  - Total SHIFT time is CFG_BITS*2*SCLK_DIV cycles. sclk returns to 0 on exit and sdi goes to 0.
- RELEASE: one cycle driving pll_nreset=1, then go to WAIT_LOCK.
- WAIT_LOCK:
  - A qualify counter increments while lock_sync=1 and clears to 0 when lock_sync=0.
  - Reaching LOCK_QUAL goes to RUN.
  - A timeout counter reaching LOCK_TIMEOUT goes to ERROR. If both occur in the same cycle, the lock wins.
- RUN:
  - pll_bypass=0 from the entry cycle; pclk_reset_req=0 one cycle after entry (bypass switches before reset is released).
  - cfg_done=1 and cfg_busy=0.
  - If lock_sync=0 is seen: set lock_lost, reassert pclk_reset_req, and keep bypass=0. Then go to WAIT_LOCK without a new timeout/reshift, i.e. remain busy=0.
  - Correction: on loss of lock the block returns to WAIT_LOCK, cfg_busy returns to 1, and the timeout counter restarts.
- ERROR:
  - Outputs: pll_nreset=1, pll_bypass=1, pclk_reset_req=1, cfg_error=1, cfg_busy=0.
  - Hold until the next start.
- Counters are sized to $clog2(max+1) and never wrap.

Decomposition:
- Shared package pll_cfg_pkg: the state enum (IDLE, ASSERT_RST, SHIFT, RELEASE, WAIT_LOCK, RUN, ERROR) and the default parameter constants, so the control-register map can reuse the state encoding as a status field.
- One natural sub-module, pll_cfg_shifter: the SCLK_DIV-paced serial shifter with a start/done handshake and readback capture, reusable for other serial-configured parts.

Test Plan:
- Use a reduced-parameter bench: CFG_BITS=4, SCLK_DIV=2, RESET_HOLD=3, LOCK_QUAL=2, LOCK_TIMEOUT=20.
- Reset → all outputs at their listed reset values; the start pulse held during reset is ignored.
- Nominal load:
  - Stimulus: cfg_data=4'b1011, PLL model echoing sdi on sdo, lock asserted 5 cycles after nreset rises.
  - Required: sdi sequence 1,0,1,1; exactly 4 sclk rising edges, each 2 cycles high.
  - Required: readback=4'b1011; cfg_done=1; bypass falls one cycle before pclk_reset_req falls.
- Timeout: lock never asserts → cfg_error=1 exactly 20 cycles after entering WAIT_LOCK; bypass=1, pclk_reset_req=1, busy=0.
- Glitchy lock: lock_sync pattern 1,0,1,1 → RUN is entered only after the second consecutive high; no early done.
- Lock loss in RUN: drop pll_locked → lock_lost=1, pclk_reset_req=1 within 3 cycles; re-lock → returns to RUN with lock_lost still 1.
- Abort and re-entry: cfg_start during SHIFT is ignored (readback unchanged). Reset asserted mid-SHIFT forces sclk=0 and nreset=0 on the next edge; a subsequent start completes normally.

Source files
------------

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the pixel-clock PLL configuration sequencer.
// The state encoding doubles as a status field in the control-register map.
package pll_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ASSERT_RST = 3'd1,
    SHIFT      = 3'd2,
    RELEASE    = 3'd3,
    WAIT_LOCK  = 3'd4,
    RUN        = 3'd5,
    ERROR      = 3'd6
  } state_t;

  localparam int DEF_CFG_BITS     = 26;
  localparam int DEF_SCLK_DIV     = 4;
  localparam int DEF_RESET_HOLD   = 16;
  localparam int DEF_LOCK_QUAL    = 8;
  localparam int DEF_LOCK_TIMEOUT = 65535;

  // A new load command is only honoured once the previous one has settled.
  function automatic logic accepts_start(input state_t s);
    return (s == IDLE) || (s == RUN) || (s == ERROR);
  endfunction

endpackage

// File: rtl/pll_cfg_shifter.sv
// DIV-paced serial shifter: MSB-first on sdi with an sclk of 2*DIV clk cycles per bit,
// capturing sdo into readback on every sclk rising edge.
module pll_cfg_shifter #(
  parameter int BITS = 26,
  parameter int DIV  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [BITS-1:0] data,
  input  logic            start,
  input  logic            sdo,
  output logic            sclk,
  output logic            sdi,
  output logic [BITS-1:0] readback,
  output logic            done
);

  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(BITS + 1);

  logic [BITS-1:0] sreg;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            active;
  logic            phase_end;

  assign phase_end = active && (div_cnt == DW'(DIV - 1));
  // Strobes during the final high-phase cycle so the caller can leave on the same edge.
  assign done = phase_end && sclk && (bit_cnt == BW'(BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg     <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      active   <= 1'b0;
      sclk     <= 1'b0;
      sdi      <= 1'b0;
      readback <= '0;
    end else if (load) begin
      sreg <= data;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sdi     <= sreg[BITS-1];
    end else if (phase_end) begin
      div_cnt <= '0;
      if (!sclk) begin
        sclk     <= 1'b1;
        readback <= {readback[BITS-2:0], sdo};
      end else begin
        sclk <= 1'b0;
        sreg <= {sreg[BITS-2:0], 1'b0};
        if (done) begin
          active <= 1'b0;
          sdi    <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          sdi     <= sreg[BITS-2];
        end
      end
    end else if (active) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pll_cfg_seq.sv
// Pixel-clock PLL load sequencer: reset/bypass the PLL, shift the config word,
// release, qualify lock with a timeout, then release the pixel-domain reset.
module pll_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter int CFG_BITS     = DEF_CFG_BITS,
  parameter int SCLK_DIV     = DEF_SCLK_DIV,
  parameter int RESET_HOLD   = DEF_RESET_HOLD,
  parameter int LOCK_QUAL    = DEF_LOCK_QUAL,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CFG_BITS-1:0] cfg_data,
  input  logic                cfg_start,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic                lock_lost,
  output logic [CFG_BITS-1:0] readback,
  output logic                pll_nreset,
  output logic                pll_bypass,
  output logic                pll_sclk,
  output logic                pll_sdi,
  input  logic                pll_sdo,
  input  logic                pll_locked,
  output logic                pclk_reset_req
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int QW = $clog2(LOCK_QUAL + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  state_t        state;
  logic          lock_meta;
  logic          lock_sync;
  logic [HW-1:0] hold_cnt;
  logic [QW-1:0] qual_cnt;
  logic [TW-1:0] tout_cnt;
  logic [QW-1:0] qual_nxt;
  logic [TW-1:0] tout_nxt;
  logic          accept;
  logic          shift_go;
  logic          shift_done;

  assign accept   = cfg_start && accepts_start(state);
  assign shift_go = (state == ASSERT_RST) && (hold_cnt == HW'(RESET_HOLD - 1));
  assign qual_nxt = lock_sync ? qual_cnt + 1'b1 : '0;
  assign tout_nxt = tout_cnt + 1'b1;

  // pll_locked comes from the PLL's own clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  pll_cfg_shifter #(
    .BITS (CFG_BITS),
    .DIV  (SCLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .data     (cfg_data),
    .start    (shift_go),
    .sdo      (pll_sdo),
    .sclk     (pll_sclk),
    .sdi      (pll_sdi),
    .readback (readback),
    .done     (shift_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      qual_cnt       <= '0;
      tout_cnt       <= '0;
      pll_nreset     <= 1'b0;
      pll_bypass     <= 1'b1;
      pclk_reset_req <= 1'b1;
      cfg_busy       <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_error      <= 1'b0;
      lock_lost      <= 1'b0;
    end else if (accept) begin
      state          <= ASSERT_RST;
      hold_cnt       <= '0;
      pll_nreset     <= 1'b0;
      pll_bypass     <= 1'b1;
      pclk_reset_req <= 1'b1;
      cfg_busy       <= 1'b1;
      cfg_done       <= 1'b0;
      cfg_error      <= 1'b0;
      lock_lost      <= 1'b0;
    end else begin
      case (state)
        ASSERT_RST: begin
          if (shift_go) state <= SHIFT;
          else          hold_cnt <= hold_cnt + 1'b1;
        end
        SHIFT: begin
          if (shift_done) begin
            state      <= RELEASE;
            pll_nreset <= 1'b1;
          end
        end
        RELEASE: begin
          state    <= WAIT_LOCK;
          qual_cnt <= '0;
          tout_cnt <= '0;
        end
        WAIT_LOCK: begin
          qual_cnt <= qual_nxt;
          tout_cnt <= tout_nxt;
          // Lock is checked first so a lock on the last allowed cycle still succeeds.
          if (qual_nxt == QW'(LOCK_QUAL)) begin
            state      <= RUN;
            pll_bypass <= 1'b0;
            cfg_done   <= 1'b1;
            cfg_busy   <= 1'b0;
          end else if (tout_nxt == TW'(LOCK_TIMEOUT)) begin
            state          <= ERROR;
            pll_bypass     <= 1'b1;
            pclk_reset_req <= 1'b1;
            cfg_error      <= 1'b1;
            cfg_busy       <= 1'b0;
          end
        end
        RUN: begin
          if (!lock_sync) begin
            state          <= WAIT_LOCK;
            qual_cnt       <= '0;
            tout_cnt       <= '0;
            lock_lost      <= 1'b1;
            pclk_reset_req <= 1'b1;
            cfg_busy       <= 1'b1;
          end else begin
            // Bypass already dropped on entry; the pixel reset follows one cycle later.
            pclk_reset_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
